// File: rtl/cgra_pkg.sv
// Shared types and constants for the CGRA vector issue controller.
// Instruction field positions follow the RISC-V vector encoding.
package cgra_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        WB    = 3'd4
    } state_e;

    localparam logic [6:0] OP_VECTOR = 7'b1010111;

    localparam int FUNCT6_HI = 31;
    localparam int FUNCT6_LO = 26;
    localparam int RD_HI     = 11;
    localparam int RD_LO     = 7;

    localparam int LANES_DEFAULT = 4;

    function automatic logic [5:0] get_funct6(input logic [31:0] inst);
        return inst[FUNCT6_HI:FUNCT6_LO];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] inst);
        return inst[RD_HI:RD_LO];
    endfunction

endpackage

// File: rtl/cgra_vec_issue_ctrl_if.sv
// Decode, CGRA and write-back signals of the vector issue controller.
// master = controller side, slave = decode/CGRA/register-file side.
interface cgra_vec_issue_ctrl_if
    import cgra_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT,
    parameter int VLW   = 8
);
    localparam int LENW = $clog2(LANES) + 1;

    logic            vec_valid_i;
    logic [31:0]     vec_inst_i;
    logic [VLW-1:0]  vl_i;
    logic            vec_ready_o;
    logic            stall_o;
    logic            cgra_cfg_valid_o;
    logic [5:0]      cgra_cfg_op_o;
    logic            cgra_req_o;
    logic [VLW-1:0]  cgra_idx_o;
    logic [LENW-1:0] cgra_len_o;
    logic            cgra_ack_i;
    logic            cgra_done_i;
    logic            wb_valid_o;
    logic [4:0]      wb_rd_o;

    modport master (
        input  vec_valid_i, vec_inst_i, vl_i, cgra_ack_i, cgra_done_i,
        output vec_ready_o, stall_o, cgra_cfg_valid_o, cgra_cfg_op_o,
               cgra_req_o, cgra_idx_o, cgra_len_o, wb_valid_o, wb_rd_o
    );

    modport slave (
        output vec_valid_i, vec_inst_i, vl_i, cgra_ack_i, cgra_done_i,
        input  vec_ready_o, stall_o, cgra_cfg_valid_o, cgra_cfg_op_o,
               cgra_req_o, cgra_idx_o, cgra_len_o, wb_valid_o, wb_rd_o
    );

endinterface

// File: rtl/cgra_chunk_counter.sv
// Element offset / remaining-count tracker that splits a vector into
// chunks of at most LANES elements.
module cgra_chunk_counter #(
    parameter int LANES = 4,
    parameter int VLW   = 8,
    parameter int LENW  = $clog2(LANES) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [VLW-1:0]  vl_i,
    input  logic            ack_i,
    output logic [VLW-1:0]  idx_o,
    output logic [LENW-1:0] len_o,
    output logic            last_o
);

    logic [VLW-1:0] idx_q, idx_d;
    logic [VLW-1:0] rem_q, rem_d;
    logic [LENW-1:0] len;

    // len never exceeds rem_q, so neither rem_q nor idx_q can wrap.
    always_comb begin
        if (int'(rem_q) < LANES) begin
            len = LENW'(rem_q);
        end else begin
            len = LENW'(LANES);
        end
    end

    always_comb begin
        idx_d = idx_q;
        rem_d = rem_q;
        if (load_i) begin
            idx_d = '0;
            rem_d = vl_i;
        end else if (ack_i) begin
            idx_d = idx_q + VLW'(len);
            rem_d = rem_q - VLW'(len);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q <= '0;
            rem_q <= '0;
        end else begin
            idx_q <= idx_d;
            rem_q <= rem_d;
        end
    end

    assign idx_o  = idx_q;
    assign len_o  = len;
    assign last_o = (rem_q == VLW'(len));

endmodule

// File: rtl/cgra_vec_issue_ctrl.sv
// Sequences one vector instruction onto the CGRA: config pulse, chunked
// issue, completion wait, scalar write-back. Optional WAIT watchdog: CGRA_ISSUE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a new instruction, pipeline running
// CFG   | one-cycle opcode configuration pulse
// ISSUE | presenting element chunks until the last one is acked
// WAIT  | waiting for CGRA completion
// WB    | one-cycle register-file write-back
module cgra_vec_issue_ctrl
    import cgra_pkg::*;
#(
    parameter int LANES   = LANES_DEFAULT,
    parameter int VLW     = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cgra_vec_issue_ctrl_if.master bus,
    output logic                  err_o
);

    localparam int LENW = $clog2(LANES) + 1;

    state_e      state_q, state_d;
    logic        vec_ready_q, vec_ready_d;
    logic        stall_q, stall_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic        req_q, req_d;
    logic        wb_valid_q, wb_valid_d;
    logic [5:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;

    logic            accept;
    logic            chunk_ack;
    logic            chunk_last;
    logic [VLW-1:0]  chunk_idx;
    logic [LENW-1:0] chunk_len;

    assign accept    = (state_q == IDLE) && bus.vec_valid_i;
    assign chunk_ack = (state_q == ISSUE) && bus.cgra_ack_i;

    cgra_chunk_counter #(
        .LANES (LANES),
        .VLW   (VLW),
        .LENW  (LENW)
    ) u_chunk_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (accept),
        .vl_i   (bus.vl_i),
        .ack_i  (chunk_ack),
        .idx_o  (chunk_idx),
        .len_o  (chunk_len),
        .last_o (chunk_last)
    );

`ifdef CGRA_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
`ifdef CGRA_ISSUE_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.vec_valid_i) begin
                    op_d    = get_funct6(bus.vec_inst_i);
                    rd_d    = get_rd(bus.vec_inst_i);
                    state_d = (bus.vl_i == '0) ? WB : CFG;
                end
            end
            CFG: state_d = ISSUE;
            ISSUE: begin
                if (chunk_ack && chunk_last) begin
                    state_d = WAIT;
`ifdef CGRA_ISSUE_TIMEOUT_EN
                    wd_d    = TW'(TIMEOUT - 1);
`endif
                end
            end
            WAIT: begin
                if (bus.cgra_done_i) begin
                    state_d = WB;
`ifdef CGRA_ISSUE_TIMEOUT_EN
                end else if (wd_q == '0) begin
                    // Give up on the CGRA: flag it and drop the write-back.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d    = wd_q - 1'b1;
`endif
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        vec_ready_d = (state_d == IDLE);
        stall_d     = (state_d != IDLE);
        cfg_valid_d = (state_d == CFG);
        req_d       = (state_d == ISSUE);
        wb_valid_d  = (state_d == WB);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            vec_ready_q <= 1'b1;
            stall_q     <= 1'b0;
            cfg_valid_q <= 1'b0;
            req_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            vec_ready_q <= vec_ready_d;
            stall_q     <= stall_d;
            cfg_valid_q <= cfg_valid_d;
            req_q       <= req_d;
            wb_valid_q  <= wb_valid_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
        end
    end

`ifdef CGRA_ISSUE_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign bus.vec_ready_o      = vec_ready_q;
    assign bus.stall_o          = stall_q;
    assign bus.cgra_cfg_valid_o = cfg_valid_q;
    assign bus.cgra_cfg_op_o    = op_q;
    assign bus.cgra_req_o       = req_q;
    assign bus.cgra_idx_o       = chunk_idx;
    assign bus.cgra_len_o       = chunk_len;
    assign bus.wb_valid_o       = wb_valid_q;
    assign bus.wb_rd_o          = rd_q;

endmodule
